// File: rtl/obi_mem_responder.sv
// OBI responder: byte-enabled word memory, LFSR grant stalls, per-transaction response delay, in-order response FIFO.
// Optional build macro OBI_RESP_PROTO_CHECK_EN adds a sticky check that a stalled request is held stable.
module obi_mem_responder #(
    parameter int          MEM_ADDR_WIDTH = 16,
    parameter int          DEPTH          = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        stall_en_i,
    input  logic [3:0]  stall_thresh_i,
    input  logic [2:0]  resp_delay_i,
    output logic        proto_err_o
);

    localparam int WORDS = 2 ** (MEM_ADDR_WIDTH - 2);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]               r_mem [WORDS];
    logic [31:0]               r_fifo_data [DEPTH];
    logic [2:0]                r_fifo_dly [DEPTH];
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [3:0]                r_count;
    logic [15:0]               r_lfsr;

    logic                      w_stall;
    logic                      w_gnt;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_rvalid;
    logic                      w_head_wait;
    logic                      w_lfsr_fb;
    logic [MEM_ADDR_WIDTH-3:0] w_word_idx;
    logic                      w_unused_addr;

    assign w_word_idx    = addr_i[MEM_ADDR_WIDTH-1:2];
    assign w_unused_addr = ^{addr_i[31:MEM_ADDR_WIDTH], addr_i[1:0]};

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_stall   = stall_en_i && (r_lfsr[3:0] < stall_thresh_i);

    // No bypass: a full queue refuses grant even while the head is popping.
    assign w_gnt  = rst_ni && req_i && !w_stall && (r_count < 4'(DEPTH));
    assign w_push = w_gnt;

    assign w_rvalid    = (r_count != 4'd0) && (r_fifo_dly[r_rd_ptr] == 3'd0);
    assign w_head_wait = (r_count != 4'd0) && (r_fifo_dly[r_rd_ptr] != 3'd0);
    assign w_pop       = w_rvalid;

    assign gnt_o    = w_gnt;
    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_rvalid ? r_fifo_data[r_rd_ptr] : 32'd0;

    // Storage is intentionally unreset so memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= we_i ? 32'd0 : r_mem[w_word_idx];
            r_fifo_dly[r_wr_ptr]  <= resp_delay_i;
        end
        if (w_head_wait) begin
            r_fifo_dly[r_rd_ptr] <= r_fifo_dly[r_rd_ptr] - 3'd1;
        end
        if (w_push && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr   <= LFSR_SEED;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef OBI_RESP_PROTO_CHECK_EN
    logic        r_pend;
    logic [68:0] r_snap;
    logic        r_proto_err;
    logic [68:0] w_fields;
    logic        w_viol;

    assign w_fields    = {addr_i, we_i, be_i, wdata_i};
    assign w_viol      = r_pend && (!req_i || (w_fields != r_snap));
    assign proto_err_o = r_proto_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend      <= 1'b0;
            r_snap      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pend <= req_i && !w_gnt;
            r_snap <= w_fields;
            if (w_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && w_viol) begin
            $error("obi_mem_responder: request withdrawn or changed while stalled");
        end
    end
`endif
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: data path, byte enables, latency/ordering, LFSR stalls, aliasing, reset.
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall_en;
    logic [3:0]  stall_thresh;
    logic [2:0]  resp_delay;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_gnt;
    logic        s_rv;
    logic [31:0] s_rdata;
    logic        s_perr;
    logic [15:0] m_lfsr;

    obi_mem_responder #(.MEM_ADDR_WIDTH(16), .DEPTH(2), .LFSR_SEED(16'hACE1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .stall_en_i(stall_en), .stall_thresh_i(stall_thresh), .resp_delay_i(resp_delay),
        .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    // Reference stall LFSR: x^16 + x^14 + x^13 + x^11, shifting every cycle out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample mid-cycle; the transfer happens at the next posedge.
    task automatic cyc(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic [2:0] dly);
        @(negedge clk);
        req = r; addr = a; we = w; be = b; wdata = d; resp_delay = dly;
        #1;
        s_gnt = gnt; s_rv = rvalid; s_rdata = rdata; s_perr = proto_err;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 3'd0);
    endtask

    initial begin
        int n_gnt;
        int n_rv;
        logic prev_gnt;
        logic exp_perr;

        rst_n = 1'b0; req = 1'b1; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
        stall_en = 1'b0; stall_thresh = 4'd0; resp_delay = 3'd0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt", {31'd0, gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        req = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Write then read, then a single-byte write and read back.
        cyc(1, 32'h100, 1, 4'hF, 32'hDEADBEEF, 0);
        chk("wr_gnt", {31'd0, s_gnt}, 32'd1);
        chk("wr_no_rv", {31'd0, s_rv}, 32'd0);
        cyc(1, 32'h100, 0, 4'h0, 32'h0, 0);
        chk("rd_gnt", {31'd0, s_gnt}, 32'd1);
        chk("wr_rv", {31'd0, s_rv}, 32'd1);
        chk("wr_rdata", s_rdata, 32'd0);
        cyc(1, 32'h100, 1, 4'h1, 32'h00000055, 0);
        chk("be_gnt", {31'd0, s_gnt}, 32'd1);
        chk("rd_rv", {31'd0, s_rv}, 32'd1);
        chk("rd_rdata", s_rdata, 32'hDEADBEEF);
        cyc(1, 32'h100, 0, 4'h0, 32'h0, 0);
        chk("be_wr_rdata", s_rdata, 32'd0);
        idle();
        chk("be_rd_rv", {31'd0, s_rv}, 32'd1);
        chk("be_rd_rdata", s_rdata, 32'hDEADBE55);
        idle();
        chk("drain_rv", {31'd0, s_rv}, 32'd0);
        chk("drain_rdata", s_rdata, 32'd0);

        // Latency and ordering with DEPTH=2: A delay 3, B delay 0.
        cyc(1, 32'h200, 1, 4'hF, 32'h11112222, 0);
        idle();
        cyc(1, 32'h100, 0, 4'h0, 32'h0, 3);
        chk("lat_a_gnt", {31'd0, s_gnt}, 32'd1);
        cyc(1, 32'h200, 0, 4'h0, 32'h0, 0);
        chk("lat_b_gnt", {31'd0, s_gnt}, 32'd1);
        chk("lat_c1_rv", {31'd0, s_rv}, 32'd0);
        cyc(1, 32'h200, 0, 4'h0, 32'h0, 0);
        chk("full_c2_gnt", {31'd0, s_gnt}, 32'd0);
        chk("lat_c2_rv", {31'd0, s_rv}, 32'd0);
        cyc(1, 32'h200, 0, 4'h0, 32'h0, 0);
        chk("full_c3_gnt", {31'd0, s_gnt}, 32'd0);
        chk("lat_c3_rv", {31'd0, s_rv}, 32'd0);
        cyc(1, 32'h200, 0, 4'h0, 32'h0, 0);
        chk("full_c4_gnt", {31'd0, s_gnt}, 32'd0);
        chk("lat_a_rv", {31'd0, s_rv}, 32'd1);
        chk("lat_a_rdata", s_rdata, 32'hDEADBE55);
        cyc(1, 32'h200, 0, 4'h0, 32'h0, 0);
        chk("c5_gnt", {31'd0, s_gnt}, 32'd1);
        chk("lat_b_rv", {31'd0, s_rv}, 32'd1);
        chk("lat_b_rdata", s_rdata, 32'h11112222);
        idle();
        chk("c6_rdata", s_rdata, 32'h11112222);
        idle();
        chk("c7_rv", {31'd0, s_rv}, 32'd0);

        // Random stalls at threshold 15: grant only when lfsr[3:0] == 15.
        stall_en = 1'b1; stall_thresh = 4'd15;
        n_gnt = 0; prev_gnt = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1, 32'h100, 0, 4'h0, 32'h0, 0);
            chk("stall_gnt", {31'd0, s_gnt}, {31'd0, (m_lfsr[3:0] == 4'hF)});
            chk("stall_rv", {31'd0, s_rv}, {31'd0, prev_gnt});
            if (s_gnt) n_gnt++;
            prev_gnt = s_gnt;
        end
        idle();
        chk("stall_last_rv", {31'd0, s_rv}, {31'd0, prev_gnt});
        chk("stall_some_gnt", {31'd0, n_gnt > 0}, 32'd1);
        stall_en = 1'b0; stall_thresh = 4'd0;
        idle();

        // Address aliasing above MEM_ADDR_WIDTH.
        cyc(1, 32'h0001_0004, 1, 4'hF, 32'h12345678, 0);
        cyc(1, 32'h0000_0004, 0, 4'h0, 32'h0, 0);
        idle();
        chk("alias_rv", {31'd0, s_rv}, 32'd1);
        chk("alias_rdata", s_rdata, 32'h12345678);

        // Reset with two reads pending: their responses must vanish.
        cyc(1, 32'h4, 0, 4'h0, 32'h0, 7);
        chk("pend1_gnt", {31'd0, s_gnt}, 32'd1);
        cyc(1, 32'h4, 0, 4'h0, 32'h0, 7);
        chk("pend2_gnt", {31'd0, s_gnt}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b1;
        #1;
        chk("midrst_gnt", {31'd0, gnt}, 32'd0);
        chk("midrst_rv", {31'd0, rvalid}, 32'd0);
        req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        n_rv = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (s_rv) n_rv++;
        end
        chk("post_rst_no_rv", n_rv, 32'd0);
        cyc(1, 32'h4, 0, 4'h0, 32'h0, 0);
        chk("post_rst_gnt", {31'd0, s_gnt}, 32'd1);
        idle();
        chk("post_rst_rv", {31'd0, s_rv}, 32'd1);
        chk("post_rst_rdata", s_rdata, 32'h12345678);

        // Change the address of a stalled request.
`ifdef OBI_RESP_PROTO_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        stall_en = 1'b1; stall_thresh = 4'd15;
        s_gnt = 1'b1;
        for (int i = 0; i < 20 && s_gnt; i++) begin
            cyc(1, 32'h100, 0, 4'h0, 32'h0, 0);
        end
        chk("proto_stalled", {31'd0, s_gnt}, 32'd0);
        cyc(1, 32'h104, 0, 4'h0, 32'h0, 0);
        idle();
        chk("proto_set", {31'd0, s_perr}, {31'd0, exp_perr});
        for (int i = 0; i < 3; i++) idle();
        chk("proto_sticky", {31'd0, s_perr}, {31'd0, exp_perr});
        stall_en = 1'b0;
        for (int i = 0; i < 4; i++) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
